// File: rtl/instr_fetch_rv.sv
// RV32I fetch stage: owns the PC, issues instruction-memory requests and hands
// {instruction, PC} to decode; applies redirects and traps on misalignment or timeout.
module instr_fetch_rv #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    output logic        owIMemReq,
    output logic [31:0] owIMemAddr,
    input  logic        iwIMemAck,
    input  logic [31:0] iwIMemData,
    output logic        owValid,
    input  logic        iwReady,
    output logic [31:0] owInstr,
    output logic [31:0] owPc,
    input  logic        iwRedirectValid,
    input  logic [31:0] iwRedirectPc,
    input  logic [1:0]  iwNextPcSrc,
    input  logic [19:0] iwImm20,
    input  logic [11:0] iwImm12,
    input  logic [31:0] iwRs1,
    input  logic        iwAluBit0,
    input  logic        iwBranchInverted,
    output logic        owFault
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] SRC_SEQ  = 2'd0;
    localparam logic [1:0] SRC_JAL  = 2'd1;
    localparam logic [1:0] SRC_JALR = 2'd2;
    localparam logic [1:0] SRC_B    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_pc, w_pc_nxt;
    logic            r_kill, w_kill_nxt;
    logic [TW-1:0]   r_tmo, w_tmo_nxt;
    logic [31:0]     r_instr, w_instr_nxt;
    logic [31:0]     r_pc_out, w_pc_out_nxt;
    logic            r_req, r_valid, r_fault;

    logic [31:0]     w_seq, w_jal, w_br, w_jalr, w_target;
    logic            w_taken, w_misaligned;

    assign w_seq  = iwRedirectPc + 32'd4;
    assign w_jal  = iwRedirectPc + {{11{iwImm20[19]}}, iwImm20[19], iwImm20[7:0],
                                    iwImm20[8], iwImm20[18:9], 1'b0};
    assign w_br   = iwRedirectPc + {{19{iwImm12[11]}}, iwImm12[11], iwImm12[0],
                                    iwImm12[10:5], iwImm12[4:1], 1'b0};
    assign w_jalr = (iwRs1 + {{20{iwImm12[11]}}, iwImm12}) & ~32'h0000_0001;
    assign w_taken = iwAluBit0 ^ iwBranchInverted;

    // Redirect target selection from the resolved next-PC source
    always_comb begin
        w_target = w_seq;
        case (iwNextPcSrc)
            SRC_SEQ:  w_target = w_seq;
            SRC_JAL:  w_target = w_jal;
            SRC_JALR: w_target = w_jalr;
            SRC_B:    w_target = w_taken ? w_br : w_seq;
            default:  w_target = w_seq;
        endcase
    end

    assign w_misaligned = (w_target[1:0] != 2'b00);

    // Next-state, PC, kill and timeout logic
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_kill_nxt   = r_kill;
        w_tmo_nxt    = r_tmo;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;
        case (r_state)
            ST_IDLE: begin
                w_tmo_nxt = '0;
                if (iwRedirectValid && w_misaligned) begin
                    w_state_nxt = ST_FAULT;
                end else if (iwRedirectValid) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (iwRedirectValid && w_misaligned) begin
                    w_state_nxt = ST_FAULT;
                end else if (iwIMemAck) begin
                    // Any ack ends the outstanding access; only an unkilled, unredirected one is kept
                    w_tmo_nxt = '0;
                    if (iwRedirectValid) begin
                        w_pc_nxt   = w_target;
                        w_kill_nxt = 1'b0;
                    end else if (r_kill) begin
                        w_kill_nxt = 1'b0;
                    end else begin
                        w_instr_nxt  = iwIMemData;
                        w_pc_out_nxt = r_pc;
                        w_state_nxt  = ST_HOLD;
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                    if (iwRedirectValid) begin
                        w_pc_nxt   = w_target;
                        w_kill_nxt = 1'b1;
                    end else begin
                        w_kill_nxt = r_kill;
                    end
                end
            end
            ST_HOLD: begin
                if (iwRedirectValid && w_misaligned) begin
                    w_state_nxt = ST_FAULT;
                end else if (iwRedirectValid) begin
                    w_pc_nxt    = w_target;
                    w_tmo_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end else if (iwReady) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_tmo_nxt   = '0;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; output flags are registered from the next state
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_kill   <= 1'b0;
            r_tmo    <= '0;
            r_instr  <= 32'h0000_0000;
            r_pc_out <= 32'h0000_0000;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_kill   <= w_kill_nxt;
            r_tmo    <= w_tmo_nxt;
            r_instr  <= w_instr_nxt;
            r_pc_out <= w_pc_out_nxt;
            r_req    <= (w_state_nxt == ST_FETCH);
            r_valid  <= (w_state_nxt == ST_HOLD);
            r_fault  <= (w_state_nxt == ST_FAULT);
        end
    end

    assign owIMemReq  = r_req;
    assign owIMemAddr = r_pc;
    assign owValid    = r_valid;
    assign owInstr    = r_instr;
    assign owPc       = r_pc_out;
    assign owFault    = r_fault;

endmodule

// File: tb/tb_instr_fetch_rv.sv
// Directed bench for instr_fetch_rv: sequential fetch, stalls, JAL/B/JALR redirects,
// killed acks, misaligned-target fault and fetch timeout.
module tb_instr_fetch_rv;

    logic        iwClk;
    logic        iwnRst;
    logic        owIMemReq;
    logic [31:0] owIMemAddr;
    logic        iwIMemAck;
    logic [31:0] iwIMemData;
    logic        owValid;
    logic        iwReady;
    logic [31:0] owInstr;
    logic [31:0] owPc;
    logic        iwRedirectValid;
    logic [31:0] iwRedirectPc;
    logic [1:0]  iwNextPcSrc;
    logic [19:0] iwImm20;
    logic [11:0] iwImm12;
    logic [31:0] iwRs1;
    logic        iwAluBit0;
    logic        iwBranchInverted;
    logic        owFault;

    int checks = 0;
    int errors = 0;

    instr_fetch_rv #(.RESET_PC(32'h0000_0100), .TIMEOUT(16)) dut (
        .iwClk(iwClk), .iwnRst(iwnRst),
        .owIMemReq(owIMemReq), .owIMemAddr(owIMemAddr),
        .iwIMemAck(iwIMemAck), .iwIMemData(iwIMemData),
        .owValid(owValid), .iwReady(iwReady),
        .owInstr(owInstr), .owPc(owPc),
        .iwRedirectValid(iwRedirectValid), .iwRedirectPc(iwRedirectPc),
        .iwNextPcSrc(iwNextPcSrc), .iwImm20(iwImm20), .iwImm12(iwImm12),
        .iwRs1(iwRs1), .iwAluBit0(iwAluBit0), .iwBranchInverted(iwBranchInverted),
        .owFault(owFault)
    );

    initial iwClk = 1'b0;
    always #5 iwClk = ~iwClk;

    task automatic tick();
        @(posedge iwClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic redirect(input logic [31:0] p, input logic [1:0] src, input logic [19:0] i20,
                            input logic [11:0] i12, input logic [31:0] rs1,
                            input logic alu0, input logic inv);
        iwRedirectValid  = 1'b1;
        iwRedirectPc     = p;
        iwNextPcSrc      = src;
        iwImm20          = i20;
        iwImm12          = i12;
        iwRs1            = rs1;
        iwAluBit0        = alu0;
        iwBranchInverted = inv;
    endtask

    initial begin
        iwnRst = 1'b0; iwIMemAck = 1'b0; iwIMemData = 32'h0; iwReady = 1'b0;
        iwRedirectValid = 1'b0; iwRedirectPc = 32'h0; iwNextPcSrc = 2'd0;
        iwImm20 = 20'h0; iwImm12 = 12'h0; iwRs1 = 32'h0; iwAluBit0 = 1'b0; iwBranchInverted = 1'b0;
        tick(); tick();
        chk("rst_req",   {31'd0, owIMemReq}, 32'd0);
        chk("rst_valid", {31'd0, owValid},   32'd0);
        chk("rst_fault", {31'd0, owFault},   32'd0);
        chk("rst_instr", owInstr, 32'h0);
        chk("rst_pc",    owPc,    32'h0);

        // Reset release: IDLE one cycle, then request RESET_PC
        iwnRst = 1'b1;
        tick();
        chk("first_req",  {31'd0, owIMemReq}, 32'd1);
        chk("first_addr", owIMemAddr, 32'h0000_0100);
        chk("first_nv",   {31'd0, owValid}, 32'd0);
        iwIMemAck = 1'b1; iwIMemData = 32'hAAAA_0001;
        tick();
        iwIMemAck = 1'b0;
        chk("first_valid", {31'd0, owValid}, 32'd1);
        chk("first_instr", owInstr, 32'hAAAA_0001);
        chk("first_pc",    owPc,    32'h0000_0100);
        chk("hold_noreq",  {31'd0, owIMemReq}, 32'd0);

        // Decode stalls for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, owValid}, 32'd1);
            chk("stall_instr", owInstr, 32'hAAAA_0001);
            chk("stall_pc",    owPc,    32'h0000_0100);
        end
        iwReady = 1'b1;
        tick();
        iwReady = 1'b0;
        chk("seq_nv",   {31'd0, owValid}, 32'd0);
        chk("seq_req",  {31'd0, owIMemReq}, 32'd1);
        chk("seq_addr", owIMemAddr, 32'h0000_0104);
        iwIMemAck = 1'b1; iwIMemData = 32'hAAAA_0002;
        tick();
        iwIMemAck = 1'b0;
        chk("seq_pc",    owPc,    32'h0000_0104);
        chk("seq_instr", owInstr, 32'hAAAA_0002);

        // JAL +8 from 0x200 while in HOLD, with ready also high
        redirect(32'h0000_0200, 2'd1, 20'h00800, 12'h000, 32'h0, 1'b0, 1'b0);
        iwReady = 1'b1;
        tick();
        iwRedirectValid = 1'b0; iwReady = 1'b0;
        chk("jal_drop", {31'd0, owValid}, 32'd0);
        chk("jal_req",  {31'd0, owIMemReq}, 32'd1);
        chk("jal_addr", owIMemAddr, 32'h0000_0208);
        iwIMemAck = 1'b1; iwIMemData = 32'hAAAA_0003;
        tick();
        iwIMemAck = 1'b0;
        chk("jal_pc", owPc, 32'h0000_0208);

        // BNE at 0x300, offset -4, equal -> not taken
        redirect(32'h0000_0300, 2'd3, 20'h0, 12'hFFD, 32'h0, 1'b1, 1'b1);
        tick();
        iwRedirectValid = 1'b0;
        chk("bnt_addr", owIMemAddr, 32'h0000_0304);
        iwIMemAck = 1'b1; iwIMemData = 32'hAAAA_0004;
        tick();
        iwIMemAck = 1'b0;
        chk("bnt_pc", owPc, 32'h0000_0304);
        // Not equal -> taken
        redirect(32'h0000_0300, 2'd3, 20'h0, 12'hFFD, 32'h0, 1'b0, 1'b1);
        tick();
        iwRedirectValid = 1'b0;
        chk("bt_addr", owIMemAddr, 32'h0000_02FC);
        iwIMemAck = 1'b1; iwIMemData = 32'hAAAA_0005;
        tick();
        iwIMemAck = 1'b0;
        chk("bt_pc", owPc, 32'h0000_02FC);

        // Redirect while an ack is pending: stale ack arrives three cycles later
        iwReady = 1'b1;
        tick();
        iwReady = 1'b0;
        chk("kill_pre_addr", owIMemAddr, 32'h0000_0300);
        redirect(32'h0000_0500, 2'd0, 20'h0, 12'h0, 32'h0, 1'b0, 1'b0);
        tick();
        iwRedirectValid = 1'b0;
        chk("kill_addr", owIMemAddr, 32'h0000_0504);
        chk("kill_req",  {31'd0, owIMemReq}, 32'd1);
        tick(); tick();
        iwIMemAck = 1'b1; iwIMemData = 32'hDEAD_BEEF;
        tick();
        chk("stale_nv",   {31'd0, owValid}, 32'd0);
        chk("stale_req",  {31'd0, owIMemReq}, 32'd1);
        chk("stale_addr", owIMemAddr, 32'h0000_0504);
        iwIMemData = 32'hAAAA_0006;
        tick();
        iwIMemAck = 1'b0;
        chk("kill_valid", {31'd0, owValid}, 32'd1);
        chk("kill_instr", owInstr, 32'hAAAA_0006);
        chk("kill_pc",    owPc,    32'h0000_0504);

        // Redirect in FETCH coinciding with ack: data discarded
        iwReady = 1'b1;
        tick();
        iwReady = 1'b0;
        redirect(32'h0000_0600, 2'd1, 20'h00800, 12'h0, 32'h0, 1'b0, 1'b0);
        iwIMemAck = 1'b1; iwIMemData = 32'hDEAD_0001;
        tick();
        iwRedirectValid = 1'b0; iwIMemAck = 1'b0;
        chk("rda_nv",   {31'd0, owValid}, 32'd0);
        chk("rda_addr", owIMemAddr, 32'h0000_0608);
        iwIMemAck = 1'b1; iwIMemData = 32'hAAAA_0007;
        tick();
        iwIMemAck = 1'b0;
        chk("rda_pc",    owPc,    32'h0000_0608);
        chk("rda_instr", owInstr, 32'hAAAA_0007);

        // JALR to 0x1002: misaligned -> fault
        redirect(32'h0000_0700, 2'd2, 20'h0, 12'h001, 32'h0000_1001, 1'b0, 1'b0);
        tick();
        chk("mis_fault", {31'd0, owFault}, 32'd1);
        chk("mis_req",   {31'd0, owIMemReq}, 32'd0);
        chk("mis_nv",    {31'd0, owValid}, 32'd0);
        redirect(32'h0000_0800, 2'd0, 20'h0, 12'h0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        iwRedirectValid = 1'b0;
        chk("fault_sticky", {31'd0, owFault}, 32'd1);
        chk("fault_noreq",  {31'd0, owIMemReq}, 32'd0);

        // Timeout: no ack for 16 FETCH cycles
        iwnRst = 1'b0;
        tick();
        chk("rst2_fault", {31'd0, owFault}, 32'd0);
        iwnRst = 1'b1;
        tick();
        chk("to_req", {31'd0, owIMemReq}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", {31'd0, owFault}, 32'd0);
        chk("to_req_held", {31'd0, owIMemReq}, 32'd1);
        tick();
        chk("to_fault", {31'd0, owFault}, 32'd1);
        chk("to_noreq", {31'd0, owIMemReq}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
